// File: rtl/timer_pkg.sv
// Shared timer definitions: default widths, compare reset value and the
// per-half count-update priority encoding.
package timer_pkg;

  localparam int DEF_CNT_W  = 64;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_CNT_W-1:0] TIMER_CMP_RST = {DEF_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    UPD_WR   = 2'd0,
    UPD_CLR  = 2'd1,
    UPD_INC  = 2'd2,
    UPD_HOLD = 2'd3
  } upd_op_t;

  // A write to either half freezes the other half for that cycle.
  function automatic upd_op_t half_op(input logic wr_self, input logic wr_any,
                                      input logic fall, input logic inc);
    upd_op_t op;
    if (wr_self)     op = UPD_WR;
    else if (wr_any) op = UPD_HOLD;
    else if (fall)   op = UPD_CLR;
    else if (inc)    op = UPD_INC;
    else             op = UPD_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/timer_half_reg.sv
// One half of a wide counter: load, clear, or add carry_in, with carry_out.
// Latency: 1 cycle to q; carry_out is combinational. No backpressure.
// Backpressure: none; op is applied every cycle.
module timer_half_reg
  import timer_pkg::*;
#(
  parameter int             W       = DEF_DATA_W,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [1:0]   op,
  input  logic [W-1:0] wdata,
  input  logic         carry_in,
  output logic [W-1:0] q,
  output logic         carry_out
);

  assign carry_out = carry_in & (&q);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      q <= RST_VAL;
    end else begin
      case (upd_op_t'(op))
        UPD_WR:  q <= wdata;
        UPD_CLR: q <= '0;
        UPD_INC: q <= q + W'(carry_in);
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/timer_counter.sv
// 64-bit timer count + compare with sticky match status and masked interrupt.
// Latency: count/compare 1 cycle; int_st 1 cycle after match; tim_int combinational on int_st.
// Backpressure: none; cnt_en ticks and register writes are consumed every cycle.
module timer_counter
  import timer_pkg::*;
#(
  parameter int                 CNT_W   = DEF_CNT_W,
  parameter int                 DATA_W  = DEF_DATA_W,
  parameter logic [CNT_W-1:0]   CMP_RST = TIMER_CMP_RST
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cnt_en,
  input  logic              timer_en,
  input  logic              cnt_wr_lo,
  input  logic              cnt_wr_hi,
  input  logic              cmp_wr_lo,
  input  logic              cmp_wr_hi,
  input  logic [DATA_W-1:0] cnt_wdata,
  input  logic              int_en,
  input  logic              int_st_clr,
  output logic [CNT_W-1:0]  cnt_val,
  output logic [CNT_W-1:0]  cmp_val,
  output logic              int_st,
  output logic              tim_int
);

  logic        timer_en_d;
  logic        timer_fall;
  logic        cnt_wr_any;
  logic        cmp_wr_any;
  logic        match;
  upd_op_t     cnt_lo_op, cnt_hi_op, cmp_lo_op, cmp_hi_op;
  logic        cnt_lo_co, cnt_hi_co, cmp_lo_co, cmp_hi_co;
  logic        unused_carry;

  assign timer_fall = timer_en_d & ~timer_en;
  assign cnt_wr_any = cnt_wr_lo | cnt_wr_hi;
  assign cmp_wr_any = cmp_wr_lo | cmp_wr_hi;

  always_comb begin
    cnt_lo_op = half_op(cnt_wr_lo, cnt_wr_any, timer_fall, cnt_en);
    cnt_hi_op = half_op(cnt_wr_hi, cnt_wr_any, timer_fall, cnt_en);
    // Compare never clears or counts.
    cmp_lo_op = half_op(cmp_wr_lo, cmp_wr_any, 1'b0, 1'b0);
    cmp_hi_op = half_op(cmp_wr_hi, cmp_wr_any, 1'b0, 1'b0);
  end

  timer_half_reg #(.W(DATA_W), .RST_VAL('0)) u_cnt_lo (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .op        (cnt_lo_op),
    .wdata     (cnt_wdata),
    .carry_in  (cnt_en),
    .q         (cnt_val[DATA_W-1:0]),
    .carry_out (cnt_lo_co)
  );

  timer_half_reg #(.W(DATA_W), .RST_VAL('0)) u_cnt_hi (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .op        (cnt_hi_op),
    .wdata     (cnt_wdata),
    .carry_in  (cnt_lo_co),
    .q         (cnt_val[CNT_W-1:DATA_W]),
    .carry_out (cnt_hi_co)
  );

  timer_half_reg #(.W(DATA_W), .RST_VAL(CMP_RST[DATA_W-1:0])) u_cmp_lo (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .op        (cmp_lo_op),
    .wdata     (cnt_wdata),
    .carry_in  (1'b0),
    .q         (cmp_val[DATA_W-1:0]),
    .carry_out (cmp_lo_co)
  );

  timer_half_reg #(.W(DATA_W), .RST_VAL(CMP_RST[CNT_W-1:DATA_W])) u_cmp_hi (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .op        (cmp_hi_op),
    .wdata     (cnt_wdata),
    .carry_in  (1'b0),
    .q         (cmp_val[CNT_W-1:DATA_W]),
    .carry_out (cmp_hi_co)
  );

  // Wrap out of the top half is silently dropped.
  assign unused_carry = cnt_hi_co | cmp_lo_co | cmp_hi_co;

  assign match   = (cnt_val == cmp_val);
  assign tim_int = int_st & int_en;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      timer_en_d <= 1'b0;
      int_st     <= 1'b0;
    end else begin
      timer_en_d <= timer_en;
      if (match)           int_st <= 1'b1;
      else if (int_st_clr) int_st <= 1'b0;
    end
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- 64-bit free-running timer count stage, directly downstream of the counter-control stage; consumes its one-cycle `cnt_en` tick.
- Holds the count and a 64-bit compare value, both software-writable as 32-bit halves.
- Raises a sticky match status and a maskable interrupt when count equals compare.
- Outputs feed the register block (readback) and the interrupt controller.

Parameters:
- CNT_W, 64, counter and compare width; must equal 2*DATA_W.
- DATA_W, 32, register write-data width (half of CNT_W).
- CMP_RST, all-ones (2^64-1), reset value of the compare register.

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high; clears all state.
- cnt_en  in  1  increment tick from counter control; no increment when low.
- timer_en  in  1  timer enable from the register block; its falling edge clears the count.
- cnt_wr_lo  in  1  write cnt_wdata into count bits [31:0].
- cnt_wr_hi  in  1  write cnt_wdata into count bits [63:32].
- cmp_wr_lo  in  1  write cnt_wdata into compare bits [31:0].
- cmp_wr_hi  in  1  write cnt_wdata into compare bits [63:32].
- cnt_wdata  in  DATA_W  write data shared by all four write strobes.
- int_en  in  1  interrupt mask; 1 = enabled.
- int_st_clr  in  1  write-1-to-clear pulse for the match status.
- cnt_val  out  CNT_W  current count, registered.
- cmp_val  out  CNT_W  current compare value, registered.
- int_st  out  1  sticky match status, registered.
- tim_int  out  1  interrupt request = int_st AND int_en (combinational).

Behaviour:
- Reset (asynchronous, while sys_rst=1):
  - cnt_val=0, cmp_val=CMP_RST, int_st=0, internal timer_en_d=0.
  - tim_int therefore 0.
- timer_en_d is a registered copy of timer_en. Falling edge = timer_en_d=1 AND timer_en=0.
- Count update priority, highest first, evaluated per half:
  - 1. Software write to that half: the half takes cnt_wdata. The other half holds its current value; no increment and no carry is applied to either half in that cycle.
  - 2. Falling edge of timer_en: cnt_val <= 0.
  - 3. cnt_en=1: cnt_val <= cnt_val+1, full 64-bit carry from bit 31 into bit 32.
  - 4. Otherwise hold.
- Simultaneous cnt_wr_lo and cnt_wr_hi: both halves load cnt_wdata.
- Wrap: 2^64-1 plus one tick gives 0. No overflow flag. Status is not set by the wrap unless compare=0.
- Compare register: written only by cmp_wr_lo/hi, same half semantics as the count. Unaffected by timer_en and cnt_en.
- Match: match = (cnt_val == cmp_val), combinational on registered values.
- int_st next-state, in this order:
  - set if match=1;
  - else cleared if int_st_clr=1;
  - else hold.
- Set wins over clear. A clear issued while the count still equals compare is ineffective.
- Latency:
  - the cycle cnt_val becomes equal to cmp_val, match is high;
  - int_st rises on the following edge (1 cycle);
  - tim_int follows int_st in the same cycle if int_en=1.
- A compare write that creates equality also sets int_st one cycle later.
- int_en only masks the output; int_st still sets when int_en=0.
- Halt needs no special handling: counter control holds cnt_en low, so the count freezes.
- Reset asserted mid-count: immediate asynchronous clear to reset values. After deassertion, counting resumes on the first cnt_en.

Decomposition:
- Shared timer package holds:
  - CNT_W and DATA_W defaults;
  - the CMP_RST constant;
  - the count-update priority enumeration: WR, CLR, INC, HOLD.
- One sub-module is natural: timer_half_reg, a 32-bit register with write-load, clear, increment and carry-in/carry-out. It is instantiated twice for the count (lo, hi chained by carry) and twice for the compare (increment tied off).

Test Plan:
- Reset then 5 cnt_en pulses -> cnt_val=5, cmp_val=FFFF_FFFF_FFFF_FFFF, int_st=0, tim_int=0.
- Write cnt lo=FFFF_FFFF, hi=0, then one tick -> cnt_val=0000_0001_0000_0000 (carry propagates).
- Count reaches 2^64-1, then one tick -> cnt_val=0; int_st stays 0 with compare=all-ones only if the count was not equal in a prior cycle; covers the wrap.
- Compare=10, int_en=1, tick to 10 -> int_st=1 and tim_int=1 exactly one cycle after cnt_val=10. int_st_clr while cnt_val=10 -> int_st stays 1. Tick to 11, then int_st_clr -> int_st=0.
- Count at 100, then timer_en 1->0 -> cnt_val=0 next cycle. Assert cnt_wr_lo=7 with cnt_en=1 in the same cycle -> cnt_val=7 (write beats increment).
- int_en=0 with a match -> int_st=1, tim_int=0. Set int_en=1 -> tim_int=1 in the same cycle. Assert sys_rst mid-count -> all outputs at reset values immediately.
